// File: rtl/rx_iq_phase_det_pkg.sv
// rx_iq_phase_det_pkg: shared widths, FSM states and CORDIC arctangent table
package rx_iq_phase_det_pkg;
    localparam int MPR   = 14;
    localparam int APRP  = 16;
    localparam int NITER = 14;
    localparam int XW    = MPR + 3;
    typedef enum logic [1:0] {IDLE, ROT, OUT} state_t;
    // atan(2^-i) scaled to a 2^32 full turn; narrowed with rounding for any phase width
    localparam logic [31:0] ATAN_TAB [32] = '{
        32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
        32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
        32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
        32'h00028BE6, 32'h000145F3, 32'h0000A2F9, 32'h0000517D,
        32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
        32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
        32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
        32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
    };
    function automatic logic [31:0] atan_c(input logic [4:0] i, input int aprp);
        logic [31:0] r;
        r = ATAN_TAB[i] + (32'd1 << (31 - aprp));
        return r >> (32 - aprp);
    endfunction
endpackage

// File: rtl/rx_iq_phase_det_iter.sv
// rx_cordic_vec_iter: x/y/z registers with one CORDIC vectoring micro-rotation per step
module rx_cordic_vec_iter
    import rx_iq_phase_det_pkg::*;
#(
    parameter int mpr  = MPR,
    parameter int aprp = APRP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic [mpr-1:0]  fsin_i,
    input  logic [mpr-1:0]  fcos_i,
    input  logic [4:0]      idx,
    output logic [mpr+2:0]  x_o,
    output logic [aprp-1:0] z_o
);
    localparam int xw = mpr + 3;
    logic signed [xw-1:0] x_q, x_d, y_q, y_d, s_ext, c_ext, xs, ys;
    logic [aprp-1:0] z_q, z_d, atan_v;
    logic neg, pos;
    // left half-plane inputs are pre-rotated by pi so the iterations always converge
    always_comb begin
        s_ext  = {{3{fsin_i[mpr-1]}}, fsin_i};
        c_ext  = {{3{fcos_i[mpr-1]}}, fcos_i};
        neg    = fcos_i[mpr-1];
        pos    = !y_q[xw-1];
        xs     = x_q >>> idx;
        ys     = y_q >>> idx;
        atan_v = aprp'(atan_c(idx, aprp));
        x_d    = load ? (neg ? -c_ext : c_ext) : step ? (pos ? x_q + ys : x_q - ys) : x_q;
        y_d    = load ? (neg ? -s_ext : s_ext) : step ? (pos ? y_q - xs : y_q + xs) : y_q;
        z_d    = load ? {neg, {(aprp-1){1'b0}}} : step ? (pos ? z_q + atan_v : z_q - atan_v) : z_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
            z_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            z_q <= z_d;
        end
    end
    assign x_o = x_q;
    assign z_o = z_q;
endmodule

// File: rtl/rx_iq_phase_det.sv
// rx_iq_phase_det: IQ sample to phase, phase increment and magnitude via iterative CORDIC
module rx_iq_phase_det
    import rx_iq_phase_det_pkg::*;
#(
    parameter int mpr   = MPR,
    parameter int aprp  = APRP,
    parameter int niter = NITER
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clken,
    input  logic            in_valid,
    input  logic [mpr-1:0]  fsin_i,
    input  logic [mpr-1:0]  fcos_i,
    output logic            in_ready,
    output logic [aprp-1:0] phase_o,
    output logic [aprp-1:0] freq_o,
    output logic [mpr+2:0]  mag_o,
    output logic            out_valid,
    output logic            ovf_o
);
    state_t state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [aprp-1:0] phase_q, phase_d, freq_q, freq_d, prev_q, prev_d, z;
    logic [mpr+2:0] mag_q, mag_d, x;
    logic out_valid_q, out_valid_d, ovf_q, ovf_d, first_q, first_d, zero_q, zero_d;
    logic accept, step, fin;
    rx_cordic_vec_iter #(.mpr(mpr), .aprp(aprp)) u_iter (
        .clk(clk),
        .reset(reset),
        .load(accept),
        .step(step),
        .fsin_i(fsin_i),
        .fcos_i(fcos_i),
        .idx(cnt_q),
        .x_o(x),
        .z_o(z)
    );
    // an all-zero vector has no defined angle; it reports phase 0 instead of the summed table
    always_comb begin
        accept      = clken && in_valid && state_q == IDLE;
        step        = clken && state_q == ROT;
        fin         = clken && state_q == OUT;
        state_d     = accept ? ROT : (step && cnt_q == 5'(niter - 1)) ? OUT : fin ? IDLE : state_q;
        cnt_d       = step ? cnt_q + 5'd1 : clken ? 5'd0 : cnt_q;
        zero_d      = accept ? (fsin_i == '0) && (fcos_i == '0) : zero_q;
        out_valid_d = clken ? fin : out_valid_q;
        ovf_d       = ovf_q || (clken && in_valid && state_q != IDLE);
        phase_d     = fin ? (zero_q ? '0 : z) : phase_q;
        mag_d       = fin ? x : mag_q;
        freq_d      = fin ? (first_q ? '0 : phase_d - prev_q) : freq_q;
        prev_d      = fin ? phase_d : prev_q;
        first_d     = first_q && !fin;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            phase_q     <= '0;
            freq_q      <= '0;
            prev_q      <= '0;
            mag_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            first_q     <= 1'b1;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            freq_q      <= freq_d;
            prev_q      <= prev_d;
            mag_q       <= mag_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            first_q     <= first_d;
            zero_q      <= zero_d;
        end
    end
    assign in_ready  = state_q == IDLE;
    assign phase_o   = phase_q;
    assign freq_o    = freq_q;
    assign mag_o     = mag_q;
    assign out_valid = out_valid_q;
    assign ovf_o     = ovf_q;
endmodule

// File: tb/tb_rx_iq_phase_det.sv
// tb_rx_iq_phase_det: directed and random IQ samples against a real-arithmetic CORDIC reference
module tb_rx_iq_phase_det;
    localparam int NI = 14;
    localparam real PI = 3.141592653589793;
    logic clk = 1'b0, reset = 1'b1, clken = 1'b0, in_valid = 1'b0;
    logic [13:0] fsin_i = '0, fcos_i = '0;
    logic in_ready, out_valid, ovf_o;
    logic [15:0] phase_o, freq_o;
    logic [16:0] mag_o;
    int errors = 0, checks = 0;
    int m_prev = 0;
    bit m_first = 1'b1;
    int atan_t [NI];

    always #5 clk = ~clk;

    rx_iq_phase_det dut (
        .clk(clk),
        .reset(reset),
        .clken(clken),
        .in_valid(in_valid),
        .fsin_i(fsin_i),
        .fcos_i(fcos_i),
        .in_ready(in_ready),
        .phase_o(phase_o),
        .freq_o(freq_o),
        .mag_o(mag_o),
        .out_valid(out_valid),
        .ovf_o(ovf_o)
    );

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp, input int tol = 0, input bit wrap = 1'b0);
        int d;
        d = got - exp;
        if (wrap) d = (((d % 65536) + 65536 + 32768) % 65536) - 32768;
        checks++;
        if (d > tol || d < -tol) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic void model(input int s, input int c, output int ph, output int mg);
        int x, y, z, xn;
        bit p;
        x = c < 0 ? -c : c;
        y = c < 0 ? -s : s;
        z = c < 0 ? 32768 : 0;
        for (int i = 0; i < NI; i++) begin
            p  = y >= 0;
            xn = p ? x + (y >>> i) : x - (y >>> i);
            y  = p ? y - (x >>> i) : y + (x >>> i);
            x  = xn;
            z  = p ? z + atan_t[i] : z - atan_t[i];
        end
        ph = (s == 0 && c == 0) ? 0 : (z & 65535);
        mg = x;
    endfunction

    function automatic int ideal_phase(input int s, input int c);
        return $rtoi($floor($atan2(real'(s), real'(c)) * 65536.0 / (2.0 * PI) + 0.5)) & 65535;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        clken = 1'b1;
        m_first = 1'b1;
        m_prev = 0;
    endtask

    task automatic send(input int s, input int c, input bit rnd);
        int n, lat, ph, mg, fq;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready", int'(in_ready), 1);
        fsin_i = 14'(s);
        fcos_i = 14'(c);
        in_valid = 1'b1;
        clken = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        n = 0;
        while (!out_valid && n < 200) begin
            clken = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (clken) lat++;
            n++;
        end
        model(s, c, ph, mg);
        fq = m_first ? 0 : ((ph - m_prev) & 65535);
        m_prev = ph;
        m_first = 1'b0;
        check("latency", lat, NI + 1);
        check("phase", int'(phase_o), ph);
        check("mag", int'(mag_o), mg);
        check("freq", int'(freq_o), fq);
        clken = 1'b1;
        @(negedge clk);
        check("valid_pulse", int'(out_valid), 0);
        check("phase_hold", int'(phase_o), ph);
    endtask

    initial begin
        int acc, nv, a1, a2, s, c, ang;
        real r;
        r = 1.0;
        for (int i = 0; i < NI; i++) begin
            atan_t[i] = $rtoi($floor($atan(r) * 65536.0 / (2.0 * PI) + 0.5));
            r = r / 2.0;
        end
        @(negedge clk);
        check("rst_ready", int'(in_ready), 1);
        check("rst_valid", int'(out_valid), 0);
        check("rst_ovf", int'(ovf_o), 0);
        check("rst_phase", int'(phase_o), 0);
        check("rst_freq", int'(freq_o), 0);
        check("rst_mag", int'(mag_o), 0);
        reset = 1'b0;
        clken = 1'b1;

        send(0, 8191, 1'b0);
        check("ph_near_0", int'(phase_o), 0, 4, 1'b1);
        check("freq_first", int'(freq_o), 0);
        send(8191, 0, 1'b0);
        check("ph_near_4000", int'(phase_o), 16384, 4, 1'b1);
        send(0, -8192, 1'b0);
        check("ph_near_8000", int'(phase_o), 32768, 4, 1'b1);
        send(-5792, -5792, 1'b0);
        check("ph_near_a000", int'(phase_o), 40960, 4, 1'b1);
        send(0, 0, 1'b0);
        check("zero_phase", int'(phase_o), 0);
        check("zero_mag", int'(mag_o), 0);
        send(-8192, -8192, 1'b0);
        check("ph_min", int'(phase_o), 40960, 4, 1'b1);
        send(-8192, 0, 1'b0);
        check("ph_near_c000", int'(phase_o), 49152, 4, 1'b1);
        send(8191, -8192, 1'b0);
        check("ph_near_6000", int'(phase_o), ideal_phase(8191, -8192), 4, 1'b1);

        do_reset();
        check("ovf_clear", int'(ovf_o), 0);
        fsin_i = 14'(3000);
        fcos_i = 14'(-4000);
        in_valid = 1'b1;
        acc = 0;
        nv = 0;
        a1 = -1;
        a2 = -1;
        for (int k = 0; k < 48; k++) begin
            if (in_ready) begin
                acc++;
                if (a1 < 0) a1 = k;
                else if (a2 < 0) a2 = k;
            end
            @(negedge clk);
            if (out_valid) nv++;
            if (k == 0) check("ovf_idle", int'(ovf_o), 0);
            if (k == 1) check("ovf_busy", int'(ovf_o), 1);
        end
        in_valid = 1'b0;
        check("accepts", acc, 3);
        check("accept_gap", a2 - a1, 16);
        check("results", nv, 3);
        repeat (5) @(negedge clk);
        check("ovf_sticky", int'(ovf_o), 1);
        do_reset();
        check("ovf_reset", int'(ovf_o), 0);

        fsin_i = 14'(1234);
        fcos_i = 14'(5678);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1 reset = 1'b0;
        check("abort_ready", int'(in_ready), 1);
        nv = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) nv++;
        end
        check("abort_no_valid", nv, 0);
        m_first = 1'b1;
        m_prev = 0;
        send(-2500, 6100, 1'b0);
        check("abort_fresh_freq", int'(freq_o), 0);

        for (int k = 0; k < 20; k++) begin
            s = int'($urandom_range(0, 16383)) - 8192;
            c = int'($urandom_range(0, 16383)) - 8192;
            send(s, c, 1'b1);
        end

        do_reset();
        for (int k = 0; k < 70; k++) begin
            ang = (k * 1024) & 65535;
            s = $rtoi($floor(8000.0 * $sin(real'(ang) * 2.0 * PI / 65536.0) + 0.5));
            c = $rtoi($floor(8000.0 * $cos(real'(ang) * 2.0 * PI / 65536.0) + 0.5));
            send(s, c, 1'b0);
            check("stream_phase", int'(phase_o), ang, 4, 1'b1);
            if (k == 0) check("stream_freq0", int'(freq_o), 0);
            else check("stream_freq", int'(freq_o), 1024, 6, 1'b1);
        end

        for (int k = 0; k < 30; k++) begin
            s = int'($urandom_range(0, 16383)) - 8192;
            c = int'($urandom_range(0, 16383)) - 8192;
            send(s, c, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
